// File: rtl/branch_resolver.sv
// branch_resolver
//   Sits between ID and EX, just downstream of branch_predictor. Each ID-stage
//   conditional branch is latched with its prediction, PC and taken target.
//   In EX the real condition is evaluated against the forwarded operands, the
//   predictor is trained, and a mispredict flushes IF/ID and redirects fetch.
//   Saturating counters report resolved and mispredicted branches.
//
// Ports
//   clk_i, rst_i          clock (rising edge), asynchronous active-low reset
//   stall_i               pipeline hold: latch and counters frozen, no strobe
//   flush_i               external squash of the ID-stage capture
//   id_branch_i           ID instruction is a conditional branch
//   id_predict_i          predictor decision for it (1 = taken)
//   id_funct3_i           branch type (beq/bne/blt/bge/bltu/bgeu)
//   id_pc_i, id_target_i  branch PC and computed taken target
//   ex_rs1_i, ex_rs2_i    forwarded operands in EX
//   br_valid_o            one-cycle resolve strobe to predictor Branch_i
//   br_update_o           prediction of resolving branch (predictor update_i)
//   br_result_o           actual outcome (predictor result_i)
//   mispredict_o          flush IF/ID and redirect fetch
//   redirect_pc_o         corrected fetch PC, zero unless mispredict_o
//   branch_cnt_o          resolved branches (saturating)
//   miss_cnt_o            mispredicted branches (saturating)
module branch_resolver #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             id_branch_i,
  input  logic             id_predict_i,
  input  logic [2:0]       id_funct3_i,
  input  logic [XLEN-1:0]  id_pc_i,
  input  logic [XLEN-1:0]  id_target_i,
  input  logic [XLEN-1:0]  ex_rs1_i,
  input  logic [XLEN-1:0]  ex_rs2_i,
  output logic             br_valid_o,
  output logic             br_update_o,
  output logic             br_result_o,
  output logic             mispredict_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // ID/EX latch
  logic             vld_p0;
  logic             pred_p0;
  logic [2:0]       funct3_p0;
  logic [XLEN-1:0]  pc_p0;
  logic [XLEN-1:0]  target_p0;

  // Performance counters, updated on the resolve edge
  logic [CNT_W-1:0] branch_cnt_p1;
  logic [CNT_W-1:0] miss_cnt_p1;

  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic                   actual;

  assign rs1_s = ex_rs1_i;
  assign rs2_s = ex_rs2_i;

  always_comb begin
    actual = 1'b0;
    unique case (funct3_p0)
      3'b000:  actual = (ex_rs1_i == ex_rs2_i);
      3'b001:  actual = (ex_rs1_i != ex_rs2_i);
      3'b100:  actual = (rs1_s <  rs2_s);
      3'b101:  actual = (rs1_s >= rs2_s);
      3'b110:  actual = (ex_rs1_i <  ex_rs2_i);
      3'b111:  actual = (ex_rs1_i >= ex_rs2_i);
      default: actual = 1'b0;  // 010/011 are not branches; never taken
    endcase
  end

  // EX resolve: zero-cycle, gated so nothing leaks while stalled or empty
  assign br_valid_o   = vld_p0 & ~stall_i;
  assign br_update_o  = br_valid_o & pred_p0;
  assign br_result_o  = br_valid_o & actual;
  assign mispredict_o = br_valid_o & (pred_p0 != actual);

  always_comb begin
    redirect_pc_o = '0;
    if (mispredict_o) begin
      // Predicted taken but fell through: resume at pc+4 (wraps naturally)
      redirect_pc_o = actual ? target_p0 : pc_p0 + XLEN'(4);
    end
  end

  assign branch_cnt_o = branch_cnt_p1;
  assign miss_cnt_o   = miss_cnt_p1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_p0        <= 1'b0;
      pred_p0       <= 1'b0;
      funct3_p0     <= '0;
      pc_p0         <= '0;
      target_p0     <= '0;
      branch_cnt_p1 <= '0;
      miss_cnt_p1   <= '0;
    end else if (!stall_i) begin
      // A mispredict in EX means the current ID instruction is wrong-path
      if (flush_i || mispredict_o) begin
        vld_p0 <= 1'b0;
      end else begin
        vld_p0    <= id_branch_i;
        pred_p0   <= id_predict_i;
        funct3_p0 <= id_funct3_i;
        pc_p0     <= id_pc_i;
        target_p0 <= id_target_i;
      end
      if (br_valid_o) begin
        branch_cnt_p1 <= sat_inc(branch_cnt_p1);
        if (mispredict_o) miss_cnt_p1 <= sat_inc(miss_cnt_p1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             stall_i, flush_i, id_branch_i, id_predict_i;
  logic [2:0]       id_funct3_i;
  logic [XLEN-1:0]  id_pc_i, id_target_i, ex_rs1_i, ex_rs2_i;
  logic             br_valid_o, br_update_o, br_result_o, mispredict_o;
  logic [XLEN-1:0]  redirect_pc_o;
  logic [CNT_W-1:0] branch_cnt_o, miss_cnt_o;

  branch_resolver #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .id_branch_i(id_branch_i), .id_predict_i(id_predict_i),
    .id_funct3_i(id_funct3_i), .id_pc_i(id_pc_i), .id_target_i(id_target_i),
    .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i),
    .br_valid_o(br_valid_o), .br_update_o(br_update_o),
    .br_result_o(br_result_o), .mispredict_o(mispredict_o),
    .redirect_pc_o(redirect_pc_o), .branch_cnt_o(branch_cnt_o),
    .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // One record per cycle: ID/EX inputs driven at the negedge and the
  // resolve outputs expected for the branch sitting in EX that cycle.
  typedef struct {
    logic        stall, flush, br, pred;
    logic [2:0]  f3;
    logic [31:0] pc, tgt, rs1, rs2;
    logic        e_vld, e_upd, e_res, e_mis;
    logic [31:0] e_pc;
  } vec_t;

  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   bcnt_m = 0;
  int   mcnt_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    stall_i      = v.stall;
    flush_i      = v.flush;
    id_branch_i  = v.br;
    id_predict_i = v.pred;
    id_funct3_i  = v.f3;
    id_pc_i      = v.pc;
    id_target_i  = v.tgt;
    ex_rs1_i     = v.rs1;
    ex_rs2_i     = v.rs2;
  endtask

  // Drive one cycle, queue its expectation, compare after settle, then let
  // the model counters advance for the coming rising edge.
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk_i);
    drive(v);
    exp_q.push_back(v);
    #1;
    e = exp_q.pop_front();
    check("br_valid",   32'(br_valid_o),   32'(e.e_vld));
    check("br_update",  32'(br_update_o),  32'(e.e_upd));
    check("br_result",  32'(br_result_o),  32'(e.e_res));
    check("mispredict", 32'(mispredict_o), 32'(e.e_mis));
    check("redirect",   redirect_pc_o,     e.e_pc);
    check("branch_cnt", 32'(branch_cnt_o), 32'(bcnt_m));
    check("miss_cnt",   32'(miss_cnt_o),   32'(mcnt_m));
    if (e.e_vld) begin
      if (bcnt_m < CMAX) bcnt_m++;
      if (e.e_mis && mcnt_m < CMAX) mcnt_m++;
    end
  endtask

  // Helper: no EX result expected
  function automatic vec_t idle_v(input logic br, input logic pred, input logic [2:0] f3,
                                  input logic [31:0] pc, input logic [31:0] tgt);
    vec_t v;
    v = '{1'b0, 1'b0, br, pred, f3, pc, tgt, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    //        stall flush br pred f3      pc            tgt           rs1           rs2           vld upd res mis redirect
    tbl[0]  = '{0,0, 0,0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0,        0,0,0,0, 32'h0};
    tbl[1]  = '{0,0, 1,1, 3'b000, 32'h100,      32'h140,      32'h0,        32'h0,        0,0,0,0, 32'h0};
    tbl[2]  = '{0,0, 1,0, 3'b100, 32'h180,      32'h200,      32'd5,        32'd5,        1,1,1,0, 32'h0};
    tbl[3]  = '{0,0, 1,1, 3'b001, 32'h300,      32'h340,      32'hFFFF_FFFF,32'd1,        1,0,1,1, 32'h200};
    tbl[4]  = '{0,0, 1,1, 3'b110, 32'hFFFF_FFFC,32'h10,       32'h0,        32'h0,        0,0,0,0, 32'h0};
    tbl[5]  = '{0,0, 0,0, 3'b000, 32'h0,        32'h0,        32'hFFFF_FFFF,32'd1,        1,1,0,1, 32'h0};
    tbl[6]  = '{0,0, 1,1, 3'b101, 32'h400,      32'h500,      32'h0,        32'h0,        0,0,0,0, 32'h0};
    tbl[7]  = '{0,0, 0,0, 3'b000, 32'h0,        32'h0,        32'd1,        32'd5,        1,1,0,1, 32'h404};
    tbl[8]  = '{0,0, 1,0, 3'b001, 32'h600,      32'h680,      32'h0,        32'h0,        0,0,0,0, 32'h0};
    tbl[9]  = '{0,0, 1,1, 3'b111, 32'h700,      32'h780,      32'd3,        32'd3,        1,0,0,0, 32'h0};
    tbl[10] = '{0,0, 1,1, 3'b010, 32'h800,      32'h880,      32'h8000_0000,32'd1,        1,1,1,0, 32'h0};
    tbl[11] = '{0,0, 0,0, 3'b000, 32'h0,        32'h0,        32'd7,        32'd7,        1,1,0,1, 32'h804};
    tbl[12] = '{0,0, 1,1, 3'b100, 32'h900,      32'h940,      32'h0,        32'h0,        0,0,0,0, 32'h0};
    tbl[13] = '{0,0, 0,0, 3'b000, 32'h0,        32'h0,        32'd5,        32'hFFFF_FFFF,1,1,0,1, 32'h904};
    tbl[14] = '{0,1, 1,1, 3'b000, 32'hA00,      32'hA40,      32'h0,        32'h0,        0,0,0,0, 32'h0};
    tbl[15] = '{0,0, 0,0, 3'b000, 32'h0,        32'h0,        32'd9,        32'd9,        0,0,0,0, 32'h0};

    // Reset state
    rst_i = 1'b0;
    drive(idle_v(1'b0, 1'b0, 3'b000, 32'h0, 32'h0));
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid",    32'(br_valid_o),    32'd0);
    check("rst_mis",      32'(mispredict_o),  32'd0);
    check("rst_redirect", redirect_pc_o,      32'd0);
    check("rst_bcnt",     32'(branch_cnt_o),  32'd0);
    check("rst_mcnt",     32'(miss_cnt_o),    32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Table vectors: correct/incorrect predictions, every funct3, back-to-back,
    // dropped wrong-path capture, PC wrap, flush
    for (int i = 0; i < 16; i++) step(tbl[i]);

    // Stall with a mispredicting beq in EX: nothing for 3 cycles, then one strobe
    step(idle_v(1'b1, 1'b0, 3'b000, 32'hB00, 32'hB40));
    for (int i = 0; i < 3; i++)
      step('{1,0, 1,1, 3'b001, 32'hDEAD_0000, 32'hDEAD_0040, 32'd1, 32'd1, 0,0,0,0, 32'h0});
    step('{0,0, 0,0, 3'b000, 32'h0, 32'h0, 32'd1, 32'd1, 1,0,1,1, 32'hB40});
    step('{0,0, 0,0, 3'b000, 32'h0, 32'h0, 32'd1, 32'd1, 0,0,0,0, 32'h0});

    // Asynchronous reset while a mispredicting branch is resolving
    step(idle_v(1'b1, 1'b0, 3'b000, 32'hC00, 32'hC40));
    @(negedge clk_i);
    drive('{0,0, 0,0, 3'b000, 32'h0, 32'h0, 32'd2, 32'd2, 0,0,0,0, 32'h0});
    #1;
    check("pre_rst_mis",   32'(mispredict_o), 32'd1);
    check("pre_rst_redir", redirect_pc_o,     32'hC40);
    rst_i = 1'b0;
    #1;
    check("async_rst_valid", 32'(br_valid_o),   32'd0);
    check("async_rst_mis",   32'(mispredict_o), 32'd0);
    check("async_rst_redir", redirect_pc_o,     32'd0);
    check("async_rst_bcnt",  32'(branch_cnt_o), 32'd0);
    check("async_rst_mcnt",  32'(miss_cnt_o),   32'd0);
    #1;
    rst_i  = 1'b1;
    bcnt_m = 0;
    mcnt_m = 0;
    step('{0,0, 0,0, 3'b000, 32'h0, 32'h0, 32'd2, 32'd2, 0,0,0,0, 32'h0});

    // Saturation: 20 mispredicted beq branches on a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      step(idle_v(1'b1, 1'b0, 3'b000, 32'h1000 + 32'(i * 16), 32'h2000));
      step('{0,0, 0,0, 3'b000, 32'h0, 32'h0, 32'd4, 32'd4, 1,0,1,1, 32'h2000});
    end
    step(idle_v(1'b0, 1'b0, 3'b000, 32'h0, 32'h0));
    check("sat_bcnt", 32'(branch_cnt_o), 32'(CMAX));
    check("sat_mcnt", 32'(miss_cnt_o),   32'(CMAX));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
